// File: rtl/icache_direct.sv
// icache_direct
// -------------
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// It sits between the core's instruction-fetch sram-like port and the inst
// sram-like port of the AXI bridge. Hits are answered from the line arrays
// with no downstream traffic. A miss issues one single-word read, fills the
// line and forwards the returned word to the core in the same cycle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   cpu_inst_*            upstream sram-like slave port (fetch side)
//                         req/addr in; addr_ok/data_ok/rdata out;
//                         wr/size/wdata are accepted but ignored
//   cache_inst_*          downstream sram-like master port (refill side)
//                         req/addr out (wr=0, size=word, wdata=0);
//                         addr_ok/data_ok/rdata in
module icache_direct #(
    parameter int INDEX_WIDTH  = 10,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_inst_req,
    input  logic        cpu_inst_wr,
    input  logic [1:0]  cpu_inst_size,
    input  logic [31:0] cpu_inst_addr,
    input  logic [31:0] cpu_inst_wdata,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,

    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    output logic [31:0] cache_inst_wdata,
    input  logic [31:0] cache_inst_rdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok
);

    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    // Fetch address captured at the upstream handshake; the core may change
    // cpu_inst_addr freely once addr_ok has been given.
    logic [31:0]            addr_q;

    // Only the valid bits are reset; tag/data contents are meaningless until
    // the matching valid bit is set by a fill.
    logic [LINES-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
    logic [31:0]            data_mem [LINES];

    logic [INDEX_WIDTH-1:0] line_idx;
    logic [TAG_WIDTH-1:0]   line_tag;
    logic                   hit;
    logic                   fill;

    assign line_idx = addr_q[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
    assign line_tag = addr_q[31:INDEX_WIDTH+OFFSET_WIDTH];
    assign hit      = valid_q[line_idx] && (tag_mem[line_idx] == line_tag);

    // The refill request is always a single aligned word read.
    assign cache_inst_wr    = 1'b0;
    assign cache_inst_size  = 2'b10;
    assign cache_inst_wdata = 32'd0;
    assign cache_inst_addr  = {addr_q[31:2], 2'b00};

    // Write-side fetch fields and the byte offset carry no information for
    // an aligned read-only fetch path.
    logic unused_inputs;
    assign unused_inputs = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, addr_q[1:0]};

    always_comb begin
        state_d          = state_q;
        cpu_inst_addr_ok = 1'b0;
        cpu_inst_data_ok = 1'b0;
        cpu_inst_rdata   = 32'd0;
        cache_inst_req   = 1'b0;
        fill             = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_inst_addr_ok = cpu_inst_req;
                if (cpu_inst_req) begin
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                if (hit) begin
                    cpu_inst_data_ok = 1'b1;
                    cpu_inst_rdata   = data_mem[line_idx];
                    state_d          = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end

            MISS_REQ: begin
                cache_inst_req = 1'b1;
                if (cache_inst_addr_ok) begin
                    // A bridge that answers in the accept cycle completes the
                    // refill right here instead of passing through MISS_WAIT.
                    if (cache_inst_data_ok) begin
                        fill             = 1'b1;
                        cpu_inst_data_ok = 1'b1;
                        cpu_inst_rdata   = cache_inst_rdata;
                        state_d          = IDLE;
                    end else begin
                        state_d = MISS_WAIT;
                    end
                end
            end

            MISS_WAIT: begin
                if (cache_inst_data_ok) begin
                    fill             = 1'b1;
                    cpu_inst_data_ok = 1'b1;
                    cpu_inst_rdata   = cache_inst_rdata;
                    state_d          = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset wins over everything: no handshake, no response and no fill
        // of a refill that was in flight when reset arrived.
        if (rst) begin
            state_d          = IDLE;
            cpu_inst_addr_ok = 1'b0;
            cpu_inst_data_ok = 1'b0;
            cpu_inst_rdata   = 32'd0;
            cache_inst_req   = 1'b0;
            fill             = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (cpu_inst_addr_ok) begin
                addr_q <= cpu_inst_addr;
            end
            if (fill) begin
                valid_q[line_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[line_idx]  <= line_tag;
            data_mem[line_idx] <= cache_inst_rdata;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

    localparam int LINES = 1024;

    logic        clk;
    logic        rst;
    logic        cpu_inst_req;
    logic        cpu_inst_wr;
    logic [1:0]  cpu_inst_size;
    logic [31:0] cpu_inst_addr;
    logic [31:0] cpu_inst_wdata;
    logic [31:0] cpu_inst_rdata;
    logic        cpu_inst_addr_ok;
    logic        cpu_inst_data_ok;
    logic        cache_inst_req;
    logic        cache_inst_wr;
    logic [1:0]  cache_inst_size;
    logic [31:0] cache_inst_addr;
    logic [31:0] cache_inst_wdata;
    logic [31:0] cache_inst_rdata;
    logic        cache_inst_addr_ok;
    logic        cache_inst_data_ok;

    int total = 0;
    int bad   = 0;

    // Reference model: each line index remembers which word address it holds.
    logic [31:0] model_addr [int];
    // Backing memory: fixed words from the test plan, a hash elsewhere.
    logic [31:0] mem_ovr [logic [31:0]];

    icache_direct dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_inst_req       (cpu_inst_req),
        .cpu_inst_wr        (cpu_inst_wr),
        .cpu_inst_size      (cpu_inst_size),
        .cpu_inst_addr      (cpu_inst_addr),
        .cpu_inst_wdata     (cpu_inst_wdata),
        .cpu_inst_rdata     (cpu_inst_rdata),
        .cpu_inst_addr_ok   (cpu_inst_addr_ok),
        .cpu_inst_data_ok   (cpu_inst_data_ok),
        .cache_inst_req     (cache_inst_req),
        .cache_inst_wr      (cache_inst_wr),
        .cache_inst_size    (cache_inst_size),
        .cache_inst_addr    (cache_inst_addr),
        .cache_inst_wdata   (cache_inst_wdata),
        .cache_inst_rdata   (cache_inst_rdata),
        .cache_inst_addr_ok (cache_inst_addr_ok),
        .cache_inst_data_ok (cache_inst_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    function automatic int index_of(input logic [31:0] a);
        return int'((a >> 2) % LINES);
    endfunction

    // One fetch with a downstream slave that accepts after acc_dly request
    // cycles and returns data dat_dly cycles after accepting (0 = same cycle).
    task automatic do_fetch(input logic [31:0] a, input int acc_dly, input int dat_dly,
                            input string nm);
        bit          exp_hit;
        logic [31:0] exp_data;
        int          idx;
        int          req_cycles;
        int          req_wait;
        int          since;
        int          dok;
        int          dok_cyc;
        bit          dok_with_ds;
        bit          accepted;
        bit          sent;
        bit          late_req;
        logic [31:0] got;
        idx        = index_of(a);
        exp_hit    = model_addr.exists(idx) && (model_addr[idx] == a);
        exp_data   = mem_of(a);
        req_cycles = 0; req_wait = 0; since = 0; dok = 0; dok_cyc = -1;
        dok_with_ds = 0; accepted = 0; sent = 0; late_req = 0; got = 32'd0;

        @(negedge clk);
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = a;
        cache_inst_addr_ok = 1'b0; cache_inst_data_ok = 1'b0;
        #1;
        total++;
        if (cpu_inst_addr_ok !== 1'b1) begin
            bad++; $display("FAIL %s addr_ok: got %b want 1", nm, cpu_inst_addr_ok);
        end
        total++;
        if (cpu_inst_data_ok !== 1'b0) begin
            bad++; $display("FAIL %s early data_ok: got %b want 0", nm, cpu_inst_data_ok);
        end

        for (int cyc = 1; cyc <= 40 && dok == 0; cyc++) begin
            @(negedge clk);
            cpu_inst_req       = 1'b0;
            cpu_inst_addr      = $urandom;
            cache_inst_addr_ok = 1'b0;
            cache_inst_data_ok = 1'b0;
            cache_inst_rdata   = $urandom;
            #1;
            if (accepted && cache_inst_req) late_req = 1;
            if (!accepted && cache_inst_req) begin
                if (req_wait == acc_dly) begin
                    cache_inst_addr_ok = 1'b1;
                    accepted = 1;
                    since    = 0;
                    if (dat_dly == 0) begin
                        cache_inst_data_ok = 1'b1;
                        cache_inst_rdata   = exp_data;
                        sent = 1;
                    end
                end else begin
                    req_wait++;
                end
            end else if (accepted && !sent) begin
                since++;
                if (since == dat_dly) begin
                    cache_inst_data_ok = 1'b1;
                    cache_inst_rdata   = exp_data;
                    sent = 1;
                end
            end
            #1;
            if (cache_inst_req) begin
                req_cycles++;
                total++;
                if (cache_inst_addr !== a) begin
                    bad++; $display("FAIL %s refill addr: got %h want %h", nm, cache_inst_addr, a);
                end
            end
            if (cpu_inst_data_ok === 1'b1) begin
                dok++;
                dok_cyc     = cyc;
                dok_with_ds = cache_inst_data_ok;
                got         = cpu_inst_rdata;
            end
        end
        @(negedge clk);
        cache_inst_addr_ok = 1'b0;
        cache_inst_data_ok = 1'b0;

        total++;
        if (dok != 1) begin
            bad++; $display("FAIL %s data_ok count (timeout): got %0d want 1", nm, dok);
        end
        total++;
        if (got !== exp_data) begin
            bad++; $display("FAIL %s rdata: got %h want %h", nm, got, exp_data);
        end
        if (exp_hit) begin
            total++;
            if (dok_cyc != 1) begin
                bad++; $display("FAIL %s hit latency: got cycle %0d want 1", nm, dok_cyc);
            end
            total++;
            if (req_cycles != 0) begin
                bad++; $display("FAIL %s hit refill reqs: got %0d want 0", nm, req_cycles);
            end
        end else begin
            total++;
            if (req_cycles != acc_dly + 1) begin
                bad++; $display("FAIL %s miss req cycles: got %0d want %0d", nm, req_cycles, acc_dly + 1);
            end
            total++;
            if (dok_with_ds !== 1'b1) begin
                bad++; $display("FAIL %s miss data_ok not with downstream data_ok: got %b want 1", nm, dok_with_ds);
            end
            total++;
            if (late_req) begin
                bad++; $display("FAIL %s req after accept: got 1 want 0", nm);
            end
        end
        model_addr[idx] = a;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; cpu_inst_req = 1'b1; cpu_inst_addr = 32'h1FC0_0000;
        #1;
        total++;
        if (cpu_inst_addr_ok !== 1'b0) begin
            bad++; $display("FAIL reset addr_ok during rst: got %b want 0", cpu_inst_addr_ok);
        end
        @(negedge clk);
        cpu_inst_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (cpu_inst_addr_ok !== 1'b0 || cpu_inst_data_ok !== 1'b0 || cpu_inst_rdata !== 32'd0) begin
            bad++; $display("FAIL reset cpu outs: got %b %b %h want 0 0 0",
                            cpu_inst_addr_ok, cpu_inst_data_ok, cpu_inst_rdata);
        end
        total++;
        if (cache_inst_req !== 1'b0 || cache_inst_addr !== 32'd0) begin
            bad++; $display("FAIL reset refill outs: got %b %h want 0 0", cache_inst_req, cache_inst_addr);
        end
        total++;
        if (cache_inst_wr !== 1'b0 || cache_inst_size !== 2'b10 || cache_inst_wdata !== 32'd0) begin
            bad++; $display("FAIL reset constants: got %b %b %h want 0 10 0",
                            cache_inst_wr, cache_inst_size, cache_inst_wdata);
        end
        model_addr.delete();
    endtask

    task automatic test_cold_hit_conflict();
        do_fetch(32'h1FC0_0000, 0, 3, "cold_miss");
        do_fetch(32'h1FC0_0000, 0, 0, "hit");
        do_fetch(32'h1FC0_1000, 1, 2, "conflict_miss");
        do_fetch(32'h1FC0_0000, 2, 1, "conflict_back");
    endtask

    task automatic test_same_cycle();
        do_fetch(32'h0040_0100, 1, 0, "same_cycle_miss");
        do_fetch(32'h0040_0100, 0, 0, "same_cycle_hit");
    endtask

    task automatic test_wrap();
        do_fetch(32'hFFFF_FFFC, 0, 1, "wrap_top_miss");
        do_fetch(32'h0000_0000, 0, 2, "wrap_zero_miss");
        do_fetch(32'hFFFF_FFFC, 0, 0, "wrap_top_hit");
        do_fetch(32'h0000_0000, 0, 0, "wrap_zero_hit");
    endtask

    task automatic test_back_to_back();
        int k;
        int j;
        for (int i = 0; i < 8; i++) do_fetch(32'h1FC0_0000 + 32'(4 * i), 0, 1, "b2b_fill");
        k = 0; j = 0;
        for (int cyc = 0; cyc <= 16; cyc++) begin
            @(negedge clk);
            cpu_inst_req  = (k < 8);
            cpu_inst_addr = 32'h1FC0_0000 + 32'(4 * k);
            #1;
            total++;
            if (cpu_inst_addr_ok !== ((cyc % 2 == 0) && cyc < 16)) begin
                bad++; $display("FAIL b2b addr_ok cycle %0d: got %b want %b", cyc, cpu_inst_addr_ok,
                                ((cyc % 2 == 0) && cyc < 16));
            end
            total++;
            if (cpu_inst_data_ok !== (cyc % 2 == 1)) begin
                bad++; $display("FAIL b2b data_ok cycle %0d: got %b want %b", cyc, cpu_inst_data_ok, (cyc % 2 == 1));
            end
            if (cpu_inst_data_ok === 1'b1) begin
                total++;
                if (cpu_inst_rdata !== mem_of(32'h1FC0_0000 + 32'(4 * j))) begin
                    bad++; $display("FAIL b2b rdata %0d: got %h want %h", j, cpu_inst_rdata,
                                    mem_of(32'h1FC0_0000 + 32'(4 * j)));
                end
                j++;
            end
            if (cpu_inst_addr_ok === 1'b1) k++;
        end
        @(negedge clk);
        cpu_inst_req = 1'b0;
        total++;
        if (j != 8) begin
            bad++; $display("FAIL b2b pulses: got %0d want 8", j);
        end
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] a;
        bit          seen;
        a = 32'h2000_0040;
        @(negedge clk);
        cpu_inst_req = 1'b1; cpu_inst_addr = a;
        #1;
        total++;
        if (cpu_inst_addr_ok !== 1'b1) begin
            bad++; $display("FAIL rst_mid addr_ok: got %b want 1", cpu_inst_addr_ok);
        end
        @(negedge clk);
        cpu_inst_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (cache_inst_req === 1'b1) begin
                cache_inst_addr_ok = 1'b1;
                seen = 1;
            end
            @(negedge clk);
            cache_inst_addr_ok = 1'b0;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL rst_mid refill req (timeout): got 0 want 1");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cache_inst_data_ok = 1'b1;
        cache_inst_rdata   = mem_of(a);
        #1;
        total++;
        if (cpu_inst_data_ok !== 1'b0 || cache_inst_req !== 1'b0) begin
            bad++; $display("FAIL rst_mid stale data_ok: got %b %b want 0 0", cpu_inst_data_ok, cache_inst_req);
        end
        @(negedge clk);
        cache_inst_data_ok = 1'b0;
        model_addr.delete();
        do_fetch(a, 0, 1, "rst_mid_refetch");
        do_fetch(32'h1FC0_0000, 0, 1, "rst_mid_old_line");
    endtask

    task automatic test_random();
        logic [19:0] tag_pool [4];
        logic [9:0]  idx_pool [4];
        logic [31:0] a;
        tag_pool[0] = 20'h1FC00; tag_pool[1] = 20'h1FC01; tag_pool[2] = 20'h00000; tag_pool[3] = 20'hFFFFF;
        idx_pool[0] = 10'd0;     idx_pool[1] = 10'd1;     idx_pool[2] = 10'd7;     idx_pool[3] = 10'd1023;
        for (int n = 0; n < 60; n++) begin
            a = {tag_pool[$urandom_range(0, 3)], idx_pool[$urandom_range(0, 3)], 2'b00};
            do_fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_inst_req = 1'b0; cpu_inst_wr = 1'b0; cpu_inst_size = 2'b10;
        cpu_inst_addr = 32'd0; cpu_inst_wdata = 32'd0;
        cache_inst_rdata = 32'd0; cache_inst_addr_ok = 1'b0; cache_inst_data_ok = 1'b0;
        mem_ovr[32'h1FC0_0000] = 32'h3C1A_0000;
        mem_ovr[32'h1FC0_1000] = 32'h1111_1111;

        test_reset();
        test_cold_hit_conflict();
        test_back_to_back();
        test_same_cycle();
        test_wrap();
        test_reset_mid_miss();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
